// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared types and constants for the calculator arithmetic core.
// Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_core_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_core_if
// Purpose  : Switch/button inputs and display-side outputs of the core.
// Revision : 1.0
// ============================================================================
interface calc_core_if #(
    parameter int WIDTH = calc_pkg::CALC_WIDTH
);
    logic [WIDTH-1:0] sw_val;
    logic [1:0]       op_sel;
    logic             enter;
    logic             clear;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             ovf;
    logic             busy;

    modport master (
        output sw_val, op_sel, enter, clear,
        input  result, result_valid, ovf, busy
    );

    modport slave (
        input  sw_val, op_sel, enter, clear,
        output result, result_valid, ovf, busy
    );
endinterface : calc_core_if
`default_nettype wire

// File: rtl/calc_core_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult
// Purpose  : Signed shift-add multiplier, one multiplier bit per clock.
// Revision : 1.0
// ============================================================================
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic               abort,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    output logic      [2*WIDTH-1:0] product,
    output logic                    done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_run;
    logic               r_done;

    // Negating -2^(WIDTH-1) wraps to itself, which read unsigned is the true magnitude.
    assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            // Bit 0 is folded into the load so the product is ready WIDTH cycles later.
            r_acc    <= w_mag_b[0] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a} << 1;
            r_mplier <= w_mag_b >> 1;
            r_cnt    <= CW'(WIDTH - 1);
            r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            r_run    <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_run) begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign product = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign done    = r_done;

endmodule : seq_mult
`default_nettype wire

// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
// Module   : calc_core
// Purpose  : Operand-entry FSM with ADD/SUB/MUL and signed overflow flag.
// Revision : 1.0
// ============================================================================
module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst,
    calc_core_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_ovf;
    logic               r_busy;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic               w_mul_done;
    logic               w_mul_start;

    assign w_sum     = r_a + r_b;
    assign w_diff    = r_a - r_b;
    assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
    assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    // Product fits only if its upper WIDTH+1 bits are a pure sign extension.
    assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || (~|w_prod[2*WIDTH-1:WIDTH-1]));

    assign w_mul_start = (r_state == S_B) && bus.enter && !bus.clear && (r_op == OP_MUL);

    seq_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .abort   (bus.clear),
        .a       (r_a),
        .b       (bus.sw_val),
        .product (w_prod),
        .done    (w_mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_A;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (bus.clear) begin
            r_state  <= S_A;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (bus.enter) begin
                        r_a     <= bus.sw_val;
                        r_op    <= op_t'(bus.op_sel);
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.enter) begin
                        r_b     <= bus.sw_val;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ADD: begin
                            r_result <= w_sum;
                            r_ovf    <= w_add_ovf;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_SHOW;
                        end
                        OP_SUB: begin
                            r_result <= w_diff;
                            r_ovf    <= w_sub_ovf;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_SHOW;
                        end
                        OP_MUL: begin
                            if ((r_cnt == '0) && w_mul_done) begin
                                r_result <= w_prod[WIDTH-1:0];
                                r_ovf    <= w_mul_ovf;
                                r_valid  <= 1'b1;
                                r_busy   <= 1'b0;
                                r_state  <= S_SHOW;
                            end else if (r_cnt != '0) begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        default: begin
                            r_result <= '0;
                            r_ovf    <= 1'b1;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_SHOW;
                        end
                    endcase
                end
                S_SHOW: begin
                    // result and ovf stay on display until the next computation lands.
                    if (bus.enter) begin
                        r_a     <= bus.sw_val;
                        r_op    <= op_t'(bus.op_sel);
                        r_valid <= 1'b0;
                        r_state <= S_B;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.ovf          = r_ovf;
    assign bus.busy         = r_busy;

endmodule : calc_core
`default_nettype wire

// File: tb/tb_calc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_core
// Purpose  : Directed self-checking bench for calc_core.
// Revision : 1.0
// ============================================================================
module tb_calc_core;
    import calc_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    calc_core_if #(.WIDTH(WIDTH)) bus ();

    calc_core #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v, input logic [1:0] op);
        bus.sw_val = v;
        bus.op_sel = op;
        bus.enter  = 1'b1;
        step();
        bus.enter  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst        = 1'b1;
        bus.sw_val = '0;
        bus.op_sel = 2'b00;
        bus.enter  = 1'b0;
        bus.clear  = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_result", 16'(bus.result), 16'h00);
        chk("rst_valid",  16'(bus.result_valid), 16'h0);
        chk("rst_ovf",    16'(bus.ovf), 16'h0);
        chk("rst_busy",   16'(bus.busy), 16'h0);

        // 5 ADD 3
        press(8'd5, 2'b00);
        chk("add_sb_valid", 16'(bus.result_valid), 16'h0);
        press(8'd3, 2'b11);
        chk("add_exec_busy",  16'(bus.busy), 16'h1);
        chk("add_exec_valid", 16'(bus.result_valid), 16'h0);
        step();
        chk("add_result", 16'(bus.result), 16'h08);
        chk("add_ovf",    16'(bus.ovf), 16'h0);
        chk("add_valid",  16'(bus.result_valid), 16'h1);
        chk("add_busy",   16'(bus.busy), 16'h0);

        // 3 SUB 5, started from S_SHOW
        press(8'd3, 2'b01);
        chk("sub_sb_valid", 16'(bus.result_valid), 16'h0);
        chk("sub_sb_hold",  16'(bus.result), 16'h08);
        press(8'd5, 2'b00);
        step();
        chk("sub_result", 16'(bus.result), 16'hFE);
        chk("sub_ovf",    16'(bus.ovf), 16'h0);
        chk("sub_valid",  16'(bus.result_valid), 16'h1);

        // 100 ADD 100 overflows
        press(8'd100, 2'b00);
        press(8'd100, 2'b00);
        step();
        chk("addovf_result", 16'(bus.result), 16'hC8);
        chk("addovf_ovf",    16'(bus.ovf), 16'h1);

        // reserved op
        press(8'd1, 2'b11);
        press(8'd2, 2'b00);
        step();
        chk("rsv_result", 16'(bus.result), 16'h00);
        chk("rsv_ovf",    16'(bus.ovf), 16'h1);
        chk("rsv_valid",  16'(bus.result_valid), 16'h1);

        // -4 MUL 3 with a stray enter mid-execution
        press(8'hFC, 2'b10);
        press(8'd3, 2'b00);
        for (int i = 1; i <= 7; i++) begin
            chk("mul_busy_in",  16'(bus.busy), 16'h1);
            chk("mul_valid_in", 16'(bus.result_valid), 16'h0);
            if (i == 3) begin
                press(8'h55, 2'b01);
            end else begin
                step();
            end
        end
        chk("mul_busy_last",  16'(bus.busy), 16'h1);
        chk("mul_valid_last", 16'(bus.result_valid), 16'h0);
        step();
        chk("mul_result", 16'(bus.result), 16'hF4);
        chk("mul_ovf",    16'(bus.ovf), 16'h0);
        chk("mul_valid",  16'(bus.result_valid), 16'h1);
        chk("mul_busy",   16'(bus.busy), 16'h0);

        // -128 MUL -1 overflows to +128
        press(8'h80, 2'b10);
        press(8'hFF, 2'b00);
        for (int i = 0; i < 7; i++) step();
        chk("mulovf_pending", 16'(bus.result_valid), 16'h0);
        step();
        chk("mulovf_result", 16'(bus.result), 16'h80);
        chk("mulovf_ovf",    16'(bus.ovf), 16'h1);
        chk("mulovf_valid",  16'(bus.result_valid), 16'h1);

        // 7 MUL 7 aborted by clear three cycles into execution
        press(8'd7, 2'b10);
        press(8'd7, 2'b00);
        step();
        step();
        step();
        chk("clr_pre_busy", 16'(bus.busy), 16'h1);
        bus.clear = 1'b1;
        bus.enter = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        chk("clr_busy",   16'(bus.busy), 16'h0);
        chk("clr_result", 16'(bus.result), 16'h00);
        chk("clr_valid",  16'(bus.result_valid), 16'h0);
        chk("clr_ovf",    16'(bus.ovf), 16'h0);

        // 2 ADD 2 after clear: first enter must be taken as operand A
        press(8'd2, 2'b00);
        chk("post_sb_busy", 16'(bus.busy), 16'h0);
        press(8'd2, 2'b10);
        chk("post_exec_busy", 16'(bus.busy), 16'h1);
        step();
        chk("post_result", 16'(bus.result), 16'h04);
        chk("post_valid",  16'(bus.result_valid), 16'h1);
        chk("post_ovf",    16'(bus.ovf), 16'h0);
        for (int i = 0; i < 10; i++) step();
        chk("post_hold", 16'(bus.result), 16'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_calc_core
`default_nettype wire

// File: doc/calc_core.md
Name: calc_core

Overview:
- Arithmetic core of the calculator, directly upstream of the 7-segment display coder.
- Captures operand A, the operation, and operand B from the switches on successive enter presses.
- Computes ADD, SUB or MUL and holds the 8-bit two's-complement result on `result`, which feeds the display coder's input.
- ADD/SUB take a single cycle; MUL is a sequential shift-add multiplier, so the core is multi-cycle and exposes `busy`.

Parameters:
- WIDTH, 8, operand and result width in bits (two's complement).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- sw_val  input  WIDTH  operand value from switches, two's complement.
- op_sel  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- enter  input  1  single-cycle pulse, already debounced and synchronised upstream.
- clear  input  1  single-cycle pulse, returns the core to operand-A entry.
- result  output  WIDTH  registered result, two's complement; drives the display coder.
- result_valid  output  1  high while `result` holds a completed computation.
- ovf  output  1  true result is not representable in WIDTH bits signed, or op was reserved.
- busy  output  1  high while in S_EXEC.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state S_A, result 0, result_valid 0, ovf 0, busy 0, internal A/B/op registers 0.
- States: S_A, S_B, S_EXEC, S_SHOW.
- S_A: on enter, latch a = sw_val and op = op_sel; go to S_B.
- S_B: on enter, latch b = sw_val; go to S_EXEC and load the iteration counter with WIDTH-1.
- S_EXEC, ADD/SUB: on the first edge in S_EXEC, register result = (a ± b) mod 2^WIDTH, set result_valid = 1, go to S_SHOW.
- S_EXEC, MUL: one multiplier bit per cycle.
  - Magnitudes of a and b are multiplied unsigned over 2·WIDTH bits.
  - The sign is applied as sign(a) XOR sign(b).
  - Result is written on the edge where the counter equals 0.
  - Result is the low WIDTH bits of the signed product.
- S_EXEC, reserved op (11): result 0, ovf 1, one cycle, go to S_SHOW.
- Latency, with enter in S_B sampled at edge k: ADD/SUB/reserved give result_valid = 1 after edge k+1; MUL gives result_valid = 1 after edge k+WIDTH.
- S_SHOW: result, ovf and result_valid hold. On enter, latch a = sw_val and op = op_sel, clear result_valid, go to S_B. result keeps its old value until the next computation completes.
- ovf, ADD: sign(a) = sign(b) and sign(result) ≠ sign(a).
- ovf, SUB: sign(a) ≠ sign(b) and sign(result) ≠ sign(a).
- ovf, MUL: 2·WIDTH signed product outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- ovf is updated only when a result is written.
- Magnitude of -2^(WIDTH-1) is handled as unsigned 2^(WIDTH-1) (WIDTH bits, no loss).
- enter while in S_EXEC is ignored; no queuing.
- clear is accepted in any state, including mid-MUL. On the next edge: state S_A, result 0, result_valid 0, ovf 0, busy 0, multiplier aborted.
- clear has priority over a simultaneous enter.
- rst has priority over everything.
- op_sel and sw_val are sampled only on accepted enter edges.
- busy = 1 exactly while the state is S_EXEC.

Decomposition:
- calc_pkg holds:
  - op_t enum: OP_ADD, OP_SUB, OP_MUL, OP_RSV.
  - state_t enum: S_A, S_B, S_EXEC, S_SHOW.
  - CALC_WIDTH = 8 default constant.
- One sub-module, seq_mult: WIDTH-bit signed shift-add multiplier.
  - Ports: clk, rst, start, abort, a, b, product[2·WIDTH-1:0], done.
  - done is a one-cycle pulse WIDTH cycles after start.
- calc_core contains the FSM, operand registers, adder/subtractor and overflow logic.

Test Plan:
- 5, ADD, 3 -> result 0x08, ovf 0, result_valid high one edge after the second enter.
- 3, SUB, 5 -> result 0xFE, ovf 0; the display coder input then shows -2.
- 100, ADD, 100 -> result 0xC8, ovf 1.
- -4 (0xFC), MUL, 3 -> result 0xF4, ovf 0.
  - busy high exactly 8 cycles.
  - result_valid high after edge k+8.
  - An extra enter pulse mid-EXEC has no effect.
- -128 (0x80), MUL, -1 (0xFF) -> result 0x80, ovf 1.
- Start 7 MUL 7, pulse clear 3 cycles into S_EXEC -> next edge: busy 0, result 0, result_valid 0, state S_A. A following 2 ADD 2 yields 0x04.
